// File: rtl/mul_seq.sv
// mul_seq: sequential unsigned shift-add multiplier.
// Two N-bit operands are captured on a start request. One partial product is
// folded in per clock over N clocks, and the full 2N-bit product is returned
// as rslt_hi:rslt. A one-cycle done pulse marks each completion.
//
// Handshake: start is sampled only when the block is not iterating, which
// means state IDLE or DONE. start is ignored while busy=1 and is not queued.
// done is high for exactly one cycle. In that cycle rslt/rslt_hi already hold
// the new product, and they keep it until the next completion. busy and done
// are never high together.
module mul_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] input1,
  input  logic [N-1:0] input2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rslt,
  output logic [N-1:0] rslt_hi,
  output logic [1:0]   state_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  mcand_q;
  logic [N-1:0]  mplier_q;
  logic [N:0]    acc_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  rslt_q;
  logic [N-1:0]  rslt_hi_q;

  logic [N:0]    sum_d;
  logic [N:0]    acc_d;
  logic [N-1:0]  mplier_d;
  logic          last_d;

  // One shift-add step: add the multiplicand when the current multiplier LSB
  // is set, then shift {sum, mplier} right by one. The N+1 bit accumulator
  // keeps the carry out of the add.
  always_comb begin
    sum_d    = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
    acc_d    = {1'b0, sum_d[N:1]};
    mplier_d = {sum_d[0], mplier_q[N-1:1]};
    last_d   = (cnt_q == CW'(N - 1));
  end

  // Control FSM and datapath registers. All outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rslt_q    <= '0;
      rslt_hi_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= input1;
            mplier_q <= input2;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last_d) begin
            // After the final shift, the accumulator holds the high half and
            // the multiplier register holds the low half.
            rslt_hi_q <= acc_d[N-1:0];
            rslt_q    <= mplier_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Accepting here skips the IDLE cycle during back-to-back use.
            mcand_q  <= input1;
            mplier_q <= input2;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rslt    = rslt_q;
  assign rslt_hi = rslt_hi_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: checks mul_seq with a fixed vector table, hand-written
// multi-cycle sequences, and random operands against a plain arithmetic model.
module tb_mul_seq;

  localparam int N = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic         busy;
  logic         done;
  logic [N-1:0] rslt;
  logic [N-1:0] rslt_hi;
  logic [1:0]   state_o;

  int n_vec;
  int n_err;
  int done_cnt;
  int overlap_cnt;
  int cyc;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t tbl[6];

  logic [2*N-1:0] exp_q[$];

  mul_seq #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .input1  (input1),
    .input2  (input2),
    .busy    (busy),
    .done    (done),
    .rslt    (rslt),
    .rslt_hi (rslt_hi),
    .state_o (state_o)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Count done pulses and busy/done overlap, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (done && busy) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for done. Operand inputs are scrambled every cycle, so a result that
  // depends on anything but the captured operands shows up as a mismatch.
  task automatic wait_done(output int lat, output int busy_cycles, output logic ok);
    ok = 1'b0;
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    while (lat < 100) begin
      input1 = N'($urandom);
      input2 = N'($urandom);
      tick();
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: no done within 100 cycles");
    end
  endtask

  // Issue one operation and check the product, latency and busy duration.
  task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N-1:0] exp);
    int lat;
    int bc;
    logic ok;
    input1 = a;
    input2 = b;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc, ok);
    if (ok) begin
      chk({name, "_product"}, {rslt_hi, rslt}, exp);
      chk({name, "_latency"}, lat, N);
      chk({name, "_busy_cycles"}, bc, N);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int c0;
    int d0;
    logic ok;
    logic [N-1:0] ra;
    logic [N-1:0] rb;

    n_vec = 0; n_err = 0; done_cnt = 0; overlap_cnt = 0; cyc = 0;
    rst = 1'b1; start = 1'b0; input1 = '0; input2 = '0;

    tbl[0] = '{a: 16'h0003, b: 16'h0005, lo: 16'h000F, hi: 16'h0000};
    tbl[1] = '{a: 16'hFFFF, b: 16'hFFFF, lo: 16'h0001, hi: 16'hFFFE};
    tbl[2] = '{a: 16'h8000, b: 16'h0002, lo: 16'h0000, hi: 16'h0001};
    tbl[3] = '{a: 16'h1234, b: 16'h0000, lo: 16'h0000, hi: 16'h0000};
    tbl[4] = '{a: 16'h1234, b: 16'h0001, lo: 16'h1234, hi: 16'h0000};
    tbl[5] = '{a: 16'h0006, b: 16'h0007, lo: 16'h002A, hi: 16'h0000};

    // Reset state.
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rslt", rslt, 0);
    chk("reset_rslt_hi", rslt_hi, 0);
    rst = 1'b0;
    tick();

    // Table-driven directed products.
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, {tbl[i].hi, tbl[i].lo});
      repeat ($urandom_range(0, 2)) tick();
    end

    // Ignored start: a second request during RUN is neither taken nor queued.
    tick();
    d0 = done_cnt;
    input1 = 16'd7; input2 = 16'd9; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    input1 = 16'd2; input2 = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bc, ok);
    if (ok) chk("ignored_start_product", {rslt_hi, rslt}, 32'h0000_003F);
    repeat (N + 5) tick();
    chk("ignored_start_done_count", done_cnt - d0, 1);
    chk("ignored_start_rslt_held", {rslt_hi, rslt}, 32'h0000_003F);

    // Back-to-back with start held high: results 17 cycles apart.
    input1 = 16'd100; input2 = 16'd200; start = 1'b1;
    tick();
    input1 = 16'hFFFF; input2 = 16'h0002;
    for (lat = 0; lat < 100 && !done; lat++) tick();
    chk("b2b_first", {rslt_hi, rslt}, 32'h0000_4E20);
    c0 = cyc;
    tick();
    start = 1'b0;
    for (lat = 0; lat < 100 && !done; lat++) tick();
    chk("b2b_second", {rslt_hi, rslt}, 32'h0001_FFFE);
    chk("b2b_spacing", cyc - c0, N + 1);
    tick();

    // Reset mid-operation, with start asserted on the same edge.
    d0 = done_cnt;
    input1 = 16'hFFFF; input2 = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rslt", rslt, 0);
    chk("abort_rslt_hi", rslt_hi, 0);
    repeat (N + 4) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_op("after_abort", 16'd6, 16'd7, 32'h0000_002A);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i % 8 == 0) ra = '1;
      if (i % 8 == 1) rb = '1;
      if (i % 8 == 2) rb = '0;
      exp_q.push_back((2*N)'(ra) * (2*N)'(rb));
      run_op($sformatf("rand%0d", i), ra, rb, exp_q.pop_front());
      repeat ($urandom_range(0, 3)) tick();
    end

    tick();
    chk("busy_done_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
